fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decode stage and its register file.
- Holds the program counter and issues word-addressed reads to the instruction memory.
- Buffers returned instructions in a small prefetch FIFO.
- Presents {instruction, pc} to decode with a valid/ready handshake; decode stalls by dropping ready.
- Accepts a branch/jump redirect that flushes all fetched-but-unconsumed work.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input and the
// {instr, pc} valid/ready handshake towards decode.
interface fetch_unit_if #(
    parameter int N  = 16,
    parameter int AW = 16
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_valid;
    logic [N-1:0]  imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          if_valid;
    logic [N-1:0]  if_instr;
    logic [AW-1:0] if_pc;
    logic          id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_valid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_valid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, one outstanding imem read, prefetch FIFO
// feeding decode, and redirect flush with stale-response dropping.
module fetch_unit #(
    parameter int            N        = 16,
    parameter int            AW       = 16,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] req_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          outstanding;
    logic          drop;
    logic [N-1:0]  fifo_instr [DEPTH];
    logic [AW-1:0] fifo_pc    [DEPTH];

    logic head_vld;
    logic resp;
    logic push;
    logic pop;
    logic issue;

    // Issue looks at the post-push/pop occupancy so a 1-cycle memory streams back-to-back.
    always_comb begin
        head_vld   = ~rst & (count != '0);
        resp       = bus.imem_valid & outstanding;
        push       = resp & ~drop & ~bus.redirect_valid;
        pop        = head_vld & bus.id_ready & ~bus.redirect_valid;
        count_next = count + CW'(push) - CW'(pop);
        issue      = ~rst & ~bus.redirect_valid & (~outstanding | bus.imem_valid)
                     & (count_next < FULL);
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.if_valid  = head_vld;
    assign bus.if_instr  = head_vld ? fifo_instr[rd_ptr] : '0;
    assign bus.if_pc     = head_vld ? fifo_pc[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // A response still on its way belongs to the old path; remember to discard it.
            if (outstanding & ~bus.imem_valid) begin
                drop        <= 1'b1;
                outstanding <= 1'b1;
            end else begin
                drop        <= 1'b0;
                outstanding <= 1'b0;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (resp) drop <= 1'b0;
            if (issue) begin
                fetch_pc    <= fetch_pc + 1'b1;
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) req_pc <= fetch_pc;
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= req_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table and corner sequences plus random
// traffic checked against a queue-based reference model.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk;
    logic rst;

    fetch_unit_if #(.N(16), .AW(16)) bus ();
    fetch_unit_if #(.N(16), .AW(4))  bus4 ();

    fetch_unit #(.N(16), .AW(16), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fetch_unit #(.N(16), .AW(4), .DEPTH(DEPTH), .RESET_PC(4'h0)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [15:0] addr; int due; } mreq_t;
    typedef struct { logic [15:0] instr; logic [15:0] pc; } ent_t;
    typedef struct { logic rdy; logic ev; logic [15:0] epc; logic ereq; logic [15:0] eaddr; } vec_t;

    mreq_t       mq[$];
    int          last_due = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    ent_t        mfifo[$];
    logic [15:0] m_pc = RESET_PC;
    logic [15:0] m_reqpc = 16'h0;
    bit          m_busy = 0;
    bit          m_stale = 0;

    logic        s_valid, s_req;
    logic [15:0] s_instr, s_pc, s_addr;

    bit          pend4 = 0;
    logic [3:0]  paddr4 = 4'h0;
    bit          collect4 = 0;
    logic [3:0]  got_pc4[$];
    logic [15:0] got_in4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        bit   ev, er, resp, push, pop;
        int   cn, lat, due;
        ent_t e;
        @(negedge clk);
        s_valid = bus.if_valid;
        s_instr = bus.if_instr;
        s_pc    = bus.if_pc;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        ev   = !rst && mfifo.size() != 0;
        resp = bus.imem_valid && m_busy;
        push = resp && !m_stale && !bus.redirect_valid;
        pop  = ev && bus.id_ready && !bus.redirect_valid;
        cn   = mfifo.size() + int'(push) - int'(pop);
        er   = !rst && !bus.redirect_valid && (!m_busy || bus.imem_valid) && cn < DEPTH;
        chk("model if_valid", 32'(s_valid), 32'(ev));
        if (ev) begin
            chk("model if_pc", 32'(s_pc), 32'(mfifo[0].pc));
            chk("model if_instr", 32'(s_instr), 32'(mfifo[0].instr));
        end
        chk("model imem_req", 32'(s_req), 32'(er));
        if (er) chk("model imem_addr", 32'(s_addr), 32'(m_pc));
        if (rst) begin
            mfifo.delete();
            m_pc = RESET_PC; m_busy = 0; m_stale = 0;
        end else if (bus.redirect_valid) begin
            mfifo.delete();
            m_pc = bus.redirect_pc;
            if (m_busy && !bus.imem_valid) m_stale = 1;
            else begin m_busy = 0; m_stale = 0; end
        end else begin
            if (pop) void'(mfifo.pop_front());
            if (push) begin
                e.instr = bus.imem_rdata; e.pc = m_reqpc;
                mfifo.push_back(e);
            end
            if (resp) begin m_busy = 0; m_stale = 0; end
            if (er) begin m_reqpc = m_pc; m_pc = m_pc + 16'd1; m_busy = 1; end
        end
        if (s_req) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{s_addr, due});
        end
        if (collect4 && bus4.if_valid && bus4.id_ready && !bus4.redirect_valid) begin
            got_pc4.push_back(bus4.if_pc);
            got_in4.push_back(bus4.if_instr);
        end
        pend4  = bus4.imem_req;
        paddr4 = bus4.imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = 16'h1000 + mq[0].addr;
            void'(mq.pop_front());
        end else begin
            bus.imem_valid = 1'b0;
            bus.imem_rdata = 16'($urandom);
        end
        bus4.imem_valid = pend4;
        bus4.imem_rdata = 16'h2000 + {12'h0, paddr4};
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus4.redirect_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    vec_t tbl[13];
    logic [3:0] wexp[4];

    initial begin
        bit found;
        tbl[0]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h1};
        tbl[2]  = '{1'b1, 1'b1, 16'h0, 1'b1, 16'h2};
        for (int i = 3; i < 9; i++) tbl[i] = '{1'b0, 1'b1, 16'h1, 1'b0, 16'h0};
        tbl[9]  = '{1'b1, 1'b1, 16'h1, 1'b1, 16'h3};
        tbl[10] = '{1'b1, 1'b1, 16'h2, 1'b1, 16'h4};
        tbl[11] = '{1'b1, 1'b1, 16'h3, 1'b1, 16'h5};
        tbl[12] = '{1'b1, 1'b1, 16'h4, 1'b1, 16'h6};
        wexp[0] = 4'hE; wexp[1] = 4'hF; wexp[2] = 4'h0; wexp[3] = 4'h1;

        rst = 1'b1;
        bus.imem_valid = 1'b0;  bus.imem_rdata = 16'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0; bus.id_ready = 1'b1;
        bus4.imem_valid = 1'b0; bus4.imem_rdata = 16'h0;
        bus4.redirect_valid = 1'b0; bus4.redirect_pc = 4'h0; bus4.id_ready = 1'b1;

        // Streaming and stall, 1-cycle memory
        lat_min = 1; lat_max = 1;
        do_reset(4);
        chk("reset if_valid", 32'(bus.if_valid), 32'h0);
        chk("reset if_instr", 32'(bus.if_instr), 32'h0);
        chk("reset if_pc", 32'(bus.if_pc), 32'h0);
        chk("reset4 if_valid", 32'(bus4.if_valid), 32'h0);
        for (int i = 0; i < 13; i++) begin
            bus.id_ready = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d if_valid", i), 32'(s_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d if_pc", i), 32'(s_pc), 32'(tbl[i].epc));
                chk($sformatf("tbl%0d if_instr", i), 32'(s_instr), 32'(16'h1000 + tbl[i].epc));
            end
            chk($sformatf("tbl%0d imem_req", i), 32'(s_req), 32'(tbl[i].ereq));
            if (tbl[i].ereq) chk($sformatf("tbl%0d imem_addr", i), 32'(s_addr), 32'(tbl[i].eaddr));
        end

        // Redirect coincident with a returning response
        bus.id_ready = 1'b1;
        do_reset(4);
        for (int i = 0; i < 4; i++) tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
        tick();
        chk("coinc no issue", 32'(s_req), 32'h0);
        bus.redirect_valid = 1'b0;
        tick();
        chk("coinc fifo empty", 32'(s_valid), 32'h0);
        chk("coinc next req", 32'(s_req), 32'h1);
        chk("coinc next addr", 32'(s_addr), 32'h0100);
        tick();
        tick();
        chk("coinc first valid", 32'(s_valid), 32'h1);
        chk("coinc first pc", 32'(s_pc), 32'h0100);

        // Redirect with a response in flight, 3-cycle memory
        lat_min = 3; lat_max = 3;
        do_reset(4);
        tick();
        chk("inflight req0", 32'(s_req), 32'h1);
        chk("inflight addr0", 32'(s_addr), 32'h0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
        tick();
        chk("inflight redirect no issue", 32'(s_req), 32'h0);
        bus.redirect_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 12; k++) begin tick(); if (s_req) begin found = 1; break; end end
        chk("inflight req seen", 32'(found), 32'h1);
        chk("inflight next addr", 32'(s_addr), 32'h0040);
        found = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (s_valid) begin found = 1; break; end end
        chk("inflight valid seen", 32'(found), 32'h1);
        chk("inflight first pc", 32'(s_pc), 32'h0040);
        chk("inflight first instr", 32'(s_instr), 32'h1040);

        // Reset while an entry is buffered and a request is outstanding
        bus.id_ready = 1'b0;
        do_reset(4);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        chk("midrst if_valid", 32'(s_valid), 32'h0);
        chk("midrst imem_req", 32'(s_req), 32'h0);
        tick();
        chk("midrst2 if_valid", 32'(s_valid), 32'h0);
        chk("midrst2 imem_req", 32'(s_req), 32'h0);
        rst = 1'b0;
        tick();
        chk("midrst restart req", 32'(s_req), 32'h1);
        chk("midrst restart addr", 32'(s_addr), 32'(RESET_PC));
        bus.id_ready = 1'b1;
        tick();
        chk("midrst late data ignored", 32'(s_valid), 32'h0);
        found = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (s_valid) begin found = 1; break; end end
        chk("midrst valid seen", 32'(found), 32'h1);
        chk("midrst first pc", 32'(s_pc), 32'(RESET_PC));

        // Random traffic against the model
        lat_min = 1; lat_max = 3;
        do_reset(4);
        for (int i = 0; i < 3000; i++) begin
            bus.id_ready       = ($urandom_range(3, 0) != 0);
            bus.redirect_valid = ($urandom_range(19, 0) == 0);
            bus.redirect_pc    = 16'($urandom);
            rst                = ($urandom_range(149, 0) == 0);
            tick();
        end

        // PC wrap-around on the narrow-address instance
        bus.id_ready = 1'b1;
        do_reset(4);
        for (int i = 0; i < 3; i++) tick();
        bus4.redirect_valid = 1'b1; bus4.redirect_pc = 4'hE;
        tick();
        bus4.redirect_valid = 1'b0;
        collect4 = 1;
        for (int k = 0; k < 20 && got_pc4.size() < 4; k++) tick();
        collect4 = 0;
        chk("wrap delivered count", 32'(got_pc4.size() >= 4), 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i < got_pc4.size()) begin
                chk($sformatf("wrap pc%0d", i), 32'(got_pc4[i]), 32'(wexp[i]));
                chk($sformatf("wrap instr%0d", i), 32'(got_in4[i]), 32'(16'h2000 + {12'h0, wexp[i]}));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
